uart_tx: RTL and testbench
==========================

Name: uart_tx

Overview:
- UART transmitter; the serial-output counterpart of the UartRx receiver block.
- Serializes 8-bit bytes as 1 start bit, 8 data bits LSB first, optional parity bit, and 1 stop bit.
- Bit timing is set by a runtime clock divider.
- A one-entry holding register lets the host queue the next byte while the current frame is on the line, so frames go out back-to-back.

Parameters:
- none; all configuration is runtime through ports

Ports:
- clock_i  input  1  system clock
- reset_i  input  1  synchronous reset, active-high
- clock_divider_i  input  16  clock cycles per serial bit; 0 is treated as 1
- parity_bit_i  input  1  1 = append a parity bit after data[7]
- parity_even_i  input  1  1 = even parity, 0 = odd parity; ignored when parity_bit_i = 0
- data_i  input  8  byte to transmit
- write_i  input  1  load data_i into the holding register; accepted only when ready_o = 1
- serial_o  output  1  TX line; idles high
- ready_o  output  1  holding register empty; a write will be accepted
- busy_o  output  1  a frame is in progress on serial_o

Behaviour:
- Reset (synchronous, dominates all other inputs):
  - serial_o = 1, ready_o = 1, busy_o = 0.
  - FSM goes to IDLE; holding register is emptied.
  - Reset mid-frame aborts the frame: serial_o is high at the first edge with reset_i = 1.
- Holding register:
  - ready_o = !hold_valid.
  - write_i = 1 with ready_o = 1 captures data_i and drives ready_o low at that edge.
  - write_i = 1 with ready_o = 0 is ignored; queued data is not overwritten.
- FSM states: IDLE, START, DATA, PARITY, STOP. All outputs are registered.
- IDLE:
  - serial_o = 1, busy_o = 0.
  - If hold_valid: transfer the holding register to the shift register and set hold_valid = 0 (ready_o rises).
  - At the same transfer, latch clock_divider_i, parity_bit_i and parity_even_i for the whole frame, and go to START.
  - Latency: a write accepted at edge N gives serial_o = 0 and busy_o = 1 from edge N+1.
- START: serial_o = 0 for D cycles, where D = max(latched divider, 1); then DATA.
- DATA:
  - serial_o = shift[0]; shift right after each bit period.
  - A 3-bit counter selects the 8 bits; each bit lasts D cycles.
  - After bit 7: go to PARITY if parity enabled, else STOP.
- PARITY: serial_o = ^byte for even parity, ~^byte for odd parity; lasts D cycles; then STOP.
- STOP:
  - serial_o = 1 for D cycles.
  - At the end, if hold_valid: perform the transfer and go directly to START (no idle gap); else go to IDLE.
- Bit-period counter:
  - 16-bit, counts 0..D-1 and wraps to 0 at each bit boundary.
  - Divider changes mid-frame have no effect.
- Frame length: (10 + parity_bit) × D cycles.
- Simultaneous write_i with a transfer: ready_o was 0 in that cycle, so the write is ignored. The host must see ready_o = 1 before writing.
- busy_o = 1 in START, DATA, PARITY and STOP.

Test Plan:
- Basic frame: divider 2, no parity, write 0x55 → serial_o = 0 for 2 cycles, then 1,0,1,0,1,0,1,0 (2 cycles each), stop high 2 cycles. busy_o is high for 20 cycles, then returns to 0.
- Parity: divider 2, write 0xAA → even parity gives a parity bit of 0 and a 22-cycle frame; odd parity gives a parity bit of 1. Repeat with 0x07 and check even parity = 1.
- Queueing: write 0x55, then 0xAA as soon as ready_o = 1 → two frames back-to-back. The 0xAA start bit begins on the cycle after the last 0x55 stop cycle, and busy_o never drops between frames.
- Overwrite protection: write 0x11 while ready_o = 0 (0x55 active, 0xAA queued) → 0x11 never appears; the frames are 0x55 then 0xAA; ready_o returns high only after 0xAA transfers.
- Reset mid-frame: assert reset_i during DATA bit 3 → next edge gives serial_o = 1, busy_o = 0, ready_o = 1; the queued byte is discarded. A new write of 0x3C then transmits correctly.
- Divider edge cases: divider 0 and divider 1 → 1 cycle per bit, 10-cycle frame. Divider changed from 2 to 5 mid-frame → current frame stays at 2 cycles per bit; the next frame uses 5.

Source files
------------

// File: rtl/uart_tx.sv
// uart_tx: UART transmitter with a one-entry holding register.
//
// Frame: 1 start bit (low), 8 data bits LSB first, optional parity bit, 1 stop bit (high).
// Each bit lasts D = max(divider, 1) clock cycles. The divider and parity settings are
// latched when a byte moves from the holding register into the shift register, so a
// frame in flight never changes shape.
//
// Ports:
//   clock_i          system clock
//   reset_i          synchronous reset, active-high
//   clock_divider_i  clock cycles per serial bit (0 behaves as 1)
//   parity_bit_i     1 = append a parity bit after data[7]
//   parity_even_i    1 = even parity, 0 = odd parity
//   data_i           byte to transmit
//   write_i          load data_i into the holding register when ready_o = 1
//   serial_o         TX line, idles high
//   ready_o          holding register empty
//   busy_o           a frame is in progress on serial_o
module uart_tx (
    input  logic        clock_i,
    input  logic        reset_i,
    input  logic [15:0] clock_divider_i,
    input  logic        parity_bit_i,
    input  logic        parity_even_i,
    input  logic [7:0]  data_i,
    input  logic        write_i,
    output logic        serial_o,
    output logic        ready_o,
    output logic        busy_o
);

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop
    } state_e;

    state_e      state_q;
    logic [7:0]  hold_q;
    logic        hold_valid_q;
    logic [7:0]  shift_q;
    logic [2:0]  bit_idx_q;
    logic [15:0] cyc_q;
    logic [15:0] div_q;
    logic        par_en_q;
    logic        par_val_q;
    logic        serial_q;
    logic        busy_q;

    logic [15:0] div_d;
    logic        par_val_d;
    logic        bit_end;
    logic        load_now;

    // Values captured for the next frame at the moment of transfer.
    assign div_d     = (clock_divider_i == 16'd0) ? 16'd1 : clock_divider_i;
    assign par_val_d = parity_even_i ? (^hold_q) : ~(^hold_q);

    assign bit_end  = (cyc_q == div_q - 16'd1);
    // Transfer from IDLE, or straight out of the last STOP cycle for back-to-back frames.
    assign load_now = hold_valid_q && ((state_q == StIdle) || ((state_q == StStop) && bit_end));

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q      <= StIdle;
            hold_q       <= 8'h00;
            hold_valid_q <= 1'b0;
            shift_q      <= 8'h00;
            bit_idx_q    <= 3'd0;
            cyc_q        <= 16'd0;
            div_q        <= 16'd1;
            par_en_q     <= 1'b0;
            par_val_q    <= 1'b0;
            serial_q     <= 1'b1;
            busy_q       <= 1'b0;
        end else begin
            // A write while the register is full is dropped; queued data is kept.
            if (write_i && !hold_valid_q) begin
                hold_q       <= data_i;
                hold_valid_q <= 1'b1;
            end

            if (state_q != StIdle) begin
                cyc_q <= bit_end ? 16'd0 : cyc_q + 16'd1;
            end

            unique case (state_q)
                StIdle: begin
                    serial_q <= 1'b1;
                    busy_q   <= 1'b0;
                    cyc_q    <= 16'd0;
                end
                StStart: begin
                    if (bit_end) begin
                        state_q   <= StData;
                        serial_q  <= shift_q[0];
                        shift_q   <= shift_q >> 1;
                        bit_idx_q <= 3'd0;
                    end
                end
                StData: begin
                    if (bit_end) begin
                        if (bit_idx_q == 3'd7) begin
                            state_q  <= par_en_q ? StParity : StStop;
                            serial_q <= par_en_q ? par_val_q : 1'b1;
                        end else begin
                            serial_q  <= shift_q[0];
                            shift_q   <= shift_q >> 1;
                            bit_idx_q <= bit_idx_q + 3'd1;
                        end
                    end
                end
                StParity: begin
                    if (bit_end) begin
                        state_q  <= StStop;
                        serial_q <= 1'b1;
                    end
                end
                StStop: begin
                    if (bit_end) begin
                        state_q  <= StIdle;
                        serial_q <= 1'b1;
                        busy_q   <= 1'b0;
                    end
                end
                default: begin
                    state_q  <= StIdle;
                    serial_q <= 1'b1;
                    busy_q   <= 1'b0;
                end
            endcase

            // Transfer overrides the per-state updates above.
            if (load_now) begin
                state_q      <= StStart;
                shift_q      <= hold_q;
                hold_valid_q <= 1'b0;
                div_q        <= div_d;
                par_en_q     <= parity_bit_i;
                par_val_q    <= par_val_d;
                cyc_q        <= 16'd0;
                serial_q     <= 1'b0;
                busy_q       <= 1'b1;
            end
        end
    end

    assign serial_o = serial_q;
    assign busy_o   = busy_q;
    assign ready_o  = !hold_valid_q;

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: directed self-checking bench for uart_tx.
module tb_uart_tx;

    logic        clock_i = 1'b0;
    logic        reset_i = 1'b1;
    logic [15:0] clock_divider_i = 16'd2;
    logic        parity_bit_i = 1'b0;
    logic        parity_even_i = 1'b1;
    logic [7:0]  data_i = 8'h00;
    logic        write_i = 1'b0;
    logic        serial_o;
    logic        ready_o;
    logic        busy_o;

    int n_total = 0;
    int n_bad   = 0;

    uart_tx dut (
        .clock_i         (clock_i),
        .reset_i         (reset_i),
        .clock_divider_i (clock_divider_i),
        .parity_bit_i    (parity_bit_i),
        .parity_even_i   (parity_even_i),
        .data_i          (data_i),
        .write_i         (write_i),
        .serial_o        (serial_o),
        .ready_o         (ready_o),
        .busy_o          (busy_o)
    );

    always #5 clock_i = ~clock_i;

    task automatic tick();
        @(posedge clock_i);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Waits (bounded) for ready_o, then presents one write for one edge.
    // Returns one cycle before the frame's first start-bit cycle when idle.
    task automatic write_byte(input logic [7:0] b);
        int n = 0;
        while (!ready_o && n < 200) begin
            tick();
            n++;
        end
        check("wait_ready", {31'd0, ready_o}, 32'd1);
        data_i  = b;
        write_i = 1'b1;
        tick();
        write_i = 1'b0;
        check("ready_low_after_write", {31'd0, ready_o}, 32'd0);
    endtask

    // Called on the first cycle of a frame; returns on the cycle after the last stop cycle.
    task automatic check_frame(input string tag, input logic [7:0] b, input int d,
                               input bit pen, input bit pbit);
        int  nbits = pen ? 11 : 10;
        logic exp_bit;
        for (int k = 0; k < nbits; k++) begin
            if (k == 0)                exp_bit = 1'b0;
            else if (k <= 8)           exp_bit = b[k-1];
            else if (pen && k == 9)    exp_bit = pbit;
            else                       exp_bit = 1'b1;
            for (int c = 0; c < d; c++) begin
                check($sformatf("%s_bit%0d_c%0d", tag, k, c), {31'd0, serial_o}, {31'd0, exp_bit});
                check($sformatf("%s_busy%0d_c%0d", tag, k, c), {31'd0, busy_o}, 32'd1);
                tick();
            end
        end
    endtask

    task automatic check_idle(input string tag, input int cycles);
        for (int i = 0; i < cycles; i++) begin
            check({tag, "_busy"}, {31'd0, busy_o}, 32'd0);
            check({tag, "_serial"}, {31'd0, serial_o}, 32'd1);
            check({tag, "_ready"}, {31'd0, ready_o}, 32'd1);
            tick();
        end
    endtask

    initial begin
        tick();
        tick();
        check("reset_serial", {31'd0, serial_o}, 32'd1);
        check("reset_ready", {31'd0, ready_o}, 32'd1);
        check("reset_busy", {31'd0, busy_o}, 32'd0);
        reset_i = 1'b0;
        tick();
        check_idle("post_reset", 2);

        // Basic frame, divider 2, no parity.
        write_byte(8'h55);
        tick();
        check_frame("basic55", 8'h55, 2, 1'b0, 1'b0);
        check_idle("basic_end", 2);

        // Parity: 0xAA has four ones.
        parity_bit_i  = 1'b1;
        parity_even_i = 1'b1;
        write_byte(8'hAA);
        tick();
        check_frame("evenAA", 8'hAA, 2, 1'b1, 1'b0);
        check_idle("evenAA_end", 1);
        parity_even_i = 1'b0;
        write_byte(8'hAA);
        tick();
        check_frame("oddAA", 8'hAA, 2, 1'b1, 1'b1);
        check_idle("oddAA_end", 1);
        parity_even_i = 1'b1;
        write_byte(8'h07);
        tick();
        check_frame("even07", 8'h07, 2, 1'b1, 1'b1);
        check_idle("even07_end", 1);
        parity_bit_i = 1'b0;

        // Queueing: second byte written as soon as ready rises.
        write_byte(8'h55);
        tick();
        check("q_ready_after_transfer", {31'd0, ready_o}, 32'd1);
        data_i  = 8'hAA;
        write_i = 1'b1;
        fork
            check_frame("q55", 8'h55, 2, 1'b0, 1'b0);
            begin
                tick();
                write_i = 1'b0;
            end
        join
        check_frame("qAA", 8'hAA, 2, 1'b0, 1'b0);
        check_idle("q_end", 2);

        // Overwrite protection: 0x11 written while full must be dropped.
        write_byte(8'h55);
        tick();
        data_i  = 8'hAA;
        write_i = 1'b1;
        fork
            check_frame("ow55", 8'h55, 2, 1'b0, 1'b0);
            begin
                tick();
                write_i = 1'b0;
                tick();
                check("ow_ready_full", {31'd0, ready_o}, 32'd0);
                data_i  = 8'h11;
                write_i = 1'b1;
                tick();
                write_i = 1'b0;
                repeat (16) tick();
                check("ow_ready_last_stop", {31'd0, ready_o}, 32'd0);
            end
        join
        check("ow_ready_after_xfer", {31'd0, ready_o}, 32'd1);
        check_frame("owAA", 8'hAA, 2, 1'b0, 1'b0);
        check_idle("ow_end", 3);

        // Reset during DATA bit 3 with a byte queued.
        write_byte(8'h55);
        tick();
        data_i  = 8'hAA;
        write_i = 1'b1;
        tick();
        write_i = 1'b0;
        repeat (7) tick();
        check("rst_at_bit3", {31'd0, serial_o}, 32'd0);
        check("rst_queued", {31'd0, ready_o}, 32'd0);
        reset_i = 1'b1;
        tick();
        check("rst_serial", {31'd0, serial_o}, 32'd1);
        check("rst_busy", {31'd0, busy_o}, 32'd0);
        check("rst_ready", {31'd0, ready_o}, 32'd1);
        reset_i = 1'b0;
        tick();
        check_idle("rst_discard", 4);
        write_byte(8'h3C);
        tick();
        check_frame("rst3C", 8'h3C, 2, 1'b0, 1'b0);
        check_idle("rst3C_end", 1);

        // Divider 0 and 1 both give one cycle per bit.
        clock_divider_i = 16'd0;
        write_byte(8'hA5);
        tick();
        check_frame("div0", 8'hA5, 1, 1'b0, 1'b0);
        check_idle("div0_end", 1);
        clock_divider_i = 16'd1;
        write_byte(8'h3C);
        tick();
        check_frame("div1", 8'h3C, 1, 1'b0, 1'b0);
        check_idle("div1_end", 1);

        // Divider change mid-frame applies only to the next frame.
        clock_divider_i = 16'd2;
        write_byte(8'h55);
        tick();
        data_i  = 8'hAA;
        write_i = 1'b1;
        fork
            check_frame("dc55", 8'h55, 2, 1'b0, 1'b0);
            begin
                tick();
                write_i = 1'b0;
                repeat (3) tick();
                clock_divider_i = 16'd5;
            end
        join
        check_frame("dcAA", 8'hAA, 5, 1'b0, 1'b0);
        check_idle("dc_end", 2);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
